// File: rtl/mdu.sv
// mdu - multiply/divide unit for the EX stage of the pipelined MIPS core.
//
// Owns the HI/LO registers. It computes mult/multu/div/divu results in one
// shot, parks them in temp_hi/temp_lo, and commits them to HI/LO once a
// countdown that models the multi-cycle latency has run out. It also serves
// mthi/mtlo (write) and mfhi/mflo (read).
//
// Ports
//   i_clk         clock; all state updates on the rising edge
//   i_rst_n       synchronous active-low reset
//   i_mduOp[4:0]  decoded MDU op (codes below; unknown codes act as DEFAULT)
//   i_start       one-cycle strobe qualifying a mult/multu/div/divu op
//   i_req         exception/interrupt this cycle; blocks new EX-stage updates
//   i_A, i_B      forwarded rs / rt operands
//   o_busy        registered; high while a mult/div is in flight
//   o_hi, o_lo    current HI / LO
//   o_mdu_result  combinational: HI for MFHI, LO for MFLO, else 0
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_mduOp,
  input  logic        i_start,
  input  logic        i_req,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic [31:0] o_mdu_result
);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MTLO  = 5'd5;
  localparam logic [4:0] OP_MTHI  = 5'd6;
  localparam logic [4:0] OP_MFLO  = 5'd7;
  localparam logic [4:0] OP_MFHI  = 5'd8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] temp_hi_q, temp_hi_d, temp_lo_q, temp_lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  // ---------------------------------------------------------------- datapath
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = 64'($signed(i_A)) * 64'($signed(i_B));
  assign prod_u = {32'd0, i_A} * {32'd0, i_B};

  // The divider input is forced to 1 when the divisor is zero so no
  // divide-by-zero is ever elaborated; that result is discarded anyway.
  logic        b_zero;
  logic [31:0] divu_b;
  assign b_zero = (i_B == 32'd0);
  assign divu_b = b_zero ? 32'd1 : i_B;

  logic [31:0] divu_q, divu_r;
  assign divu_q = i_A / divu_b;
  assign divu_r = i_A % divu_b;

  // Signed divide via magnitudes. 0x80000000 has magnitude 0x80000000 as an
  // unsigned value, so 0x80000000 / -1 yields quotient 0x80000000, rem 0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divs_qm, divs_rm, divs_q, divs_r;
  assign a_neg   = i_A[31];
  assign b_neg   = i_B[31];
  assign a_mag   = a_neg ? (32'd0 - i_A) : i_A;
  assign b_mag   = b_zero ? 32'd1 : (b_neg ? (32'd0 - i_B) : i_B);
  assign divs_qm = a_mag / b_mag;
  assign divs_rm = a_mag % b_mag;
  assign divs_q  = (a_neg ^ b_neg) ? (32'd0 - divs_qm) : divs_qm;
  assign divs_r  = a_neg ? (32'd0 - divs_rm) : divs_rm;

  // ------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;

    unique case (state_q)
      IDLE: begin
        if (!i_req) begin
          case (i_mduOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              if (i_start) begin
                state_d = RUN;
                busy_d  = 1'b1;
                case (i_mduOp)
                  OP_MULT: begin
                    {temp_hi_d, temp_lo_d} = prod_s;
                    cnt_d = 4'(MULT_CYCLES);
                  end
                  OP_MULTU: begin
                    {temp_hi_d, temp_lo_d} = prod_u;
                    cnt_d = 4'(MULT_CYCLES);
                  end
                  OP_DIV: begin
                    // Divide by zero leaves HI/LO as they are on commit.
                    temp_hi_d = b_zero ? hi_q : divs_r;
                    temp_lo_d = b_zero ? lo_q : divs_q;
                    cnt_d     = 4'(DIV_CYCLES);
                  end
                  default: begin
                    temp_hi_d = b_zero ? hi_q : divu_r;
                    temp_lo_d = b_zero ? lo_q : divu_q;
                    cnt_d     = 4'(DIV_CYCLES);
                  end
                endcase
              end
            end
            OP_MTLO: lo_d = i_A;
            OP_MTHI: hi_d = i_A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // An in-flight op belongs to an older instruction, so i_req does
        // not stop it; new starts/moves are simply not looked at here.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = temp_hi_q;
          lo_d    = temp_lo_q;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  // ----------------------------------------------------------------- outputs
  assign o_busy = busy_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

  always_comb begin
    o_mdu_result = 32'd0;
    if (i_mduOp == OP_MFHI)      o_mdu_result = hi_q;
    else if (i_mduOp == OP_MFLO) o_mdu_result = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu - self-checking bench for mdu.
// Stimulus pushes the expected busy length and committed HI/LO of each
// mult/div into a queue; a monitor pops one entry every time o_busy falls
// and compares. Direct checks cover reset state, moves and ignored requests.
module tb_mdu;

  localparam logic [4:0] OP_DEF   = 5'd0;
  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MTLO  = 5'd5;
  localparam logic [4:0] OP_MTHI  = 5'd6;
  localparam logic [4:0] OP_MFLO  = 5'd7;
  localparam logic [4:0] OP_MFHI  = 5'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  op;
  logic        start, req;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo, res;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t exp_q[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mduOp(op), .i_start(start), .i_req(req),
    .i_A(a), .i_B(b), .o_busy(busy), .o_hi(hi), .o_lo(lo), .o_mdu_result(res)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic expect_op(input string name, input int len, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.name = name; e.len = len; e.hi = h; e.lo = l;
    exp_q.push_back(e);
  endtask

  // Present one op for exactly one rising edge, then return to idle inputs.
  task automatic issue(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic s, input logic r);
    op = o; a = av; b = bv; start = s; req = r;
    @(posedge clk); #1;
    op = OP_DEF; start = 1'b0; req = 1'b0; a = 32'd0; b = 32'd0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL wait_idle: busy still 1 after 40 cycles, required 0");
    end
  endtask

  // Monitor: count busy cycles; on the falling edge compare with the queue.
  int run_len = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_op: got busy run of %0d with no expectation, required none", run_len);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn %s len=%0d hi=%08h lo=%08h", e.name, run_len, hi, lo);
        check({e.name, "_len"}, 32'(run_len), 32'(e.len));
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
      end
      run_len = 0;
    end
  end

  initial begin
    rst_n = 1'b0; op = OP_DEF; start = 1'b0; req = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    op = OP_MFHI;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_result", res, 32'd0);
    op = OP_DEF;

    // Multiplies
    expect_op("MULT", 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue(OP_MULT, 32'hFFFFFFFF, 32'h00000002, 1, 0);
    check("mult_busy_rise", 32'(busy), 32'd1);
    wait_idle();
    expect_op("MULTU", 5, 32'h00000001, 32'hFFFFFFFE);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 1, 0);
    wait_idle();

    // Divides
    expect_op("DIV", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 1, 0);
    wait_idle();
    expect_op("DIVU", 10, 32'h00000001, 32'h7FFFFFFC);
    issue(OP_DIVU, 32'hFFFFFFF9, 32'h00000002, 1, 0);
    wait_idle();
    expect_op("DIV_OVF", 10, 32'h00000000, 32'h80000000);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 0);
    wait_idle();

    // Moves, then divide by zero keeps HI/LO
    issue(OP_MTHI, 32'h12345678, 32'd0, 0, 0);
    check("mthi", hi, 32'h12345678);
    issue(OP_MTLO, 32'h9ABCDEF0, 32'd0, 0, 0);
    check("mtlo", lo, 32'h9ABCDEF0);
    expect_op("DIV0", 10, 32'h12345678, 32'h9ABCDEF0);
    issue(OP_DIV, 32'h00000055, 32'd0, 1, 0);
    wait_idle();
    op = OP_MFHI; #1;
    check("mfhi", res, 32'h12345678);
    op = OP_MFLO; #1;
    check("mflo", res, 32'h9ABCDEF0);
    op = OP_DEF;

    // Requests suppress start and moves
    issue(OP_MULT, 32'd3, 32'd3, 1, 1);
    @(negedge clk);
    check("req_busy", 32'(busy), 32'd0);
    check("req_hi", hi, 32'h12345678);
    check("req_lo", lo, 32'h9ABCDEF0);
    issue(OP_MTLO, 32'hDEADBEEF, 32'd0, 0, 1);
    check("req_mtlo", lo, 32'h9ABCDEF0);

    // Reset during cycle 4 of a divide discards it
    expect_op("DIV_RST", 4, 32'd0, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7, 1, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    expect_op("MULT_AFTER_RST", 5, 32'd0, 32'd12);
    issue(OP_MULT, 32'd3, 32'd4, 1, 0);
    check("post_rst_accept", 32'(busy), 32'd1);
    wait_idle();

    // Start while busy is ignored; start right after busy falls is taken
    expect_op("MULT_BUSY", 5, 32'd0, 32'd42);
    issue(OP_MULT, 32'd6, 32'd7, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    issue(OP_DIV, 32'd100, 32'd7, 1, 0);
    wait_idle();
    expect_op("DIV_B2B", 10, 32'd2, 32'd14);
    issue(OP_DIV, 32'd100, 32'd7, 1, 0);
    check("b2b_accept", 32'(busy), 32'd1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
